fb_pixel_writer: RTL and testbench
==================================

// Module: fb_pixel_writer
// PURPOSE
//  Sink end of the shape-renderer pixel stream: consumes x/y/cidx/drawing from a render_* block,
//  clips to the framebuffer, converts (x,y) to a linear address and issues writes to a
//  single-port framebuffer write port with ready backpressure. Drives the renderer's oe to stall
//  drawing while a write is blocked. Also provides a clear engine that fills the buffer with bg_cidx.
// PARAMETERS
//  CORDW   16               signed coordinate width (bits), matches renderer
//  CIDXW   4                colour index width (bits)
//  WIDTH   320              framebuffer width (pixels)
//  HEIGHT  180              framebuffer height (pixels)
//  ADDRW   $clog2(WIDTH*HEIGHT)  framebuffer address width (16 for 320x180)
// PORTS
//  clk        in   1      clock
//  rst        in   1      reset, synchronous, active-high
//  clear      in   1      start clear (pulse; sampled in DRAW state only)
//  bg_cidx    in   CIDXW  clear colour, sampled on the cycle clear is accepted
//  x          in   CORDW  signed pixel x from renderer
//  y          in   CORDW  signed pixel y from renderer
//  cidx       in   CIDXW  pixel colour from renderer
//  drawing    in   1      pixel valid this cycle (renderer only asserts while oe=1)
//  oe         out  1      output enable to renderer (combinational)
//  fb_we      out  1      framebuffer write request
//  fb_addr    out  ADDRW  framebuffer write address
//  fb_din     out  CIDXW  framebuffer write data
//  fb_ready   in   1      write accepted this cycle when fb_we && fb_ready
//  busy       out  1      clear in progress or write pending
//  clear_done out  1      clear complete (high for one tick)
//  clip_cnt   out  16     count of discarded off-screen pixels, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: state=DRAW, fb_we=0, fb_addr=0, fb_din=0, clear_done=0, clip_cnt=0; oe=0 while rst high.
//  Write slot: single output register (fb_we/fb_addr/fb_din); slot free when !fb_we || fb_ready.
//  oe = !rst && state==DRAW && slot free. Renderer holds x/y when oe=0; nothing lost.
//  Pixel accept: drawing=1 (implies oe=1). Next cycle: fb_we=1, fb_addr=y*WIDTH+x, fb_din=cidx.
//   Latency drawing->fb_we: 1 cycle. Back-to-back pixels at 1/cycle while fb_ready=1.
//  Clipping: x<0, x>=WIDTH, y<0 or y>=HEIGHT (signed compare) -> no write; clip_cnt+1 (saturating);
//   slot is freed as normal (fb_we=0 next cycle unless a new pixel arrives).
//  Address math: product computed at ADDRW bits only after bounds pass; never wraps.
//  fb_we holds with stable addr/din until fb_ready=1; drop of fb_ready never corrupts data.
//  States:
//   DRAW : normal pixel path. clear=1 -> CLEAR_WAIT (drawing on same cycle still accepted).
//   CLEAR_WAIT: oe=0; wait until slot free (pending pixel write completes) -> CLEAR, ptr=0.
//   CLEAR: fb_we=1, fb_addr=ptr, fb_din=bg; on fb_ready ptr+1; when write to
//          WIDTH*HEIGHT-1 accepted -> DRAW, clear_done=1 for that next cycle, fb_we=0.
//  clear asserted in CLEAR/CLEAR_WAIT: ignored (no restart). clear_done and drawing never
//   overlap a clear write. busy = state!=DRAW || fb_we.
//  Reset mid-clear or mid-write: abort immediately, no clear_done, pending write dropped.
// TESTING
//  1 Reset: hold rst 2 cycles -> fb_we=0, oe=0, clip_cnt=0; release -> oe=1 next cycle.
//  2 Single pixel x=10,y=2,cidx=5, fb_ready=1 -> next cycle fb_we=1, fb_addr=650, fb_din=5.
//  3 Stream (0,0),(319,179),(1,0) with fb_ready low 3 cycles on first -> oe=0 during stall,
//    writes addr 0,57599,1 in order, each held stable until accepted.
//  4 Clip: (-1,0),(320,5),(0,180),(5,-3) -> no fb_we, clip_cnt=4; then (0,0) writes addr 0.
//  5 clear with bg=3, fb_ready=1 -> 57600 writes addr 0..57599 data 3, oe=0 throughout,
//    clear_done one cycle after last write, oe=1 after; random fb_ready gaps -> same sequence.
//  6 rst asserted at ptr=1000 of clear -> state DRAW, fb_we=0, no clear_done; new pixel writes OK.

Source files
------------

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: clips renderer pixels and writes them to a framebuffer port; also clears the buffer.
//   clk, rst             clock, synchronous active-high reset
//   clear, bg_cidx       start a clear, clear colour (sampled when clear is accepted)
//   x, y, cidx, drawing  signed pixel stream from renderer; oe stalls the renderer
//   fb_we/addr/din       framebuffer write request, held until fb_ready
//   busy, clear_done     activity status, one-tick clear completion
//   clip_cnt             saturating count of off-screen pixels
module fb_pixel_writer #(
  parameter int CORDW  = 16,
  parameter int CIDXW  = 4,
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 180,
  parameter int ADDRW  = $clog2(WIDTH*HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CIDXW-1:0] bg_cidx,
  input  logic [CORDW-1:0] x,
  input  logic [CORDW-1:0] y,
  input  logic [CIDXW-1:0] cidx,
  input  logic             drawing,
  output logic             oe,
  output logic             fb_we,
  output logic [ADDRW-1:0] fb_addr,
  output logic [CIDXW-1:0] fb_din,
  input  logic             fb_ready,
  output logic             busy,
  output logic             clear_done,
  output logic [15:0]      clip_cnt
);
  typedef enum logic [1:0] {DRAW, CLEAR_WAIT, CLEAR} state_t;
  localparam logic [ADDRW-1:0] LAST = ADDRW'(WIDTH*HEIGHT-1);
  state_t state;
  logic [CIDXW-1:0] bg;
  logic slot_free, accept, on_screen;
  always_comb begin
    slot_free = !fb_we || fb_ready;
    oe = !rst && state == DRAW && slot_free;
    accept = drawing && oe;
    // sign bit clear means non-negative, so the upper-bound compares can be unsigned
    on_screen = !x[CORDW-1] && !y[CORDW-1] && x < CORDW'(WIDTH) && y < CORDW'(HEIGHT);
    busy = state != DRAW || fb_we;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DRAW;
      fb_we <= 1'b0;
      fb_addr <= '0;
      fb_din <= '0;
      clear_done <= 1'b0;
      clip_cnt <= '0;
      bg <= '0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        DRAW: begin
          if (slot_free) fb_we <= accept && on_screen;
          if (accept && on_screen) begin
            fb_addr <= ADDRW'(y) * ADDRW'(WIDTH) + ADDRW'(x);
            fb_din <= cidx;
          end
          if (accept && !on_screen && clip_cnt != '1) clip_cnt <= clip_cnt + 1'b1;
          if (clear) begin
            state <= CLEAR_WAIT;
            bg <= bg_cidx;
          end
        end
        CLEAR_WAIT: if (slot_free) begin
          state <= CLEAR;
          fb_we <= 1'b1;
          fb_addr <= '0;
          fb_din <= bg;
        end
        CLEAR: if (fb_ready) begin
          if (fb_addr == LAST) begin
            state <= DRAW;
            fb_we <= 1'b0;
            clear_done <= 1'b1;
          end else fb_addr <= fb_addr + 1'b1;
        end
        default: state <= DRAW;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb_fb_pixel_writer: directed table-driven and sequence checks for fb_pixel_writer.
module tb_fb_pixel_writer;
  logic clk = 0, rst = 1, clear = 0, drawing = 0, fb_ready = 0;
  logic [3:0] bg_cidx = 0, cidx = 0;
  logic [15:0] x = 0, y = 0;
  logic oe, fb_we, busy, clear_done;
  logic [15:0] fb_addr, clip_cnt;
  logic [3:0] fb_din;
  int n_chk = 0, n_fail = 0;
  typedef struct { int x; int y; int cidx; int we; int addr; } vec_t;
  vec_t v [12];
  fb_pixel_writer dut (
    .clk(clk), .rst(rst), .clear(clear), .bg_cidx(bg_cidx), .x(x), .y(y), .cidx(cidx),
    .drawing(drawing), .oe(oe), .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din),
    .fb_ready(fb_ready), .busy(busy), .clear_done(clear_done), .clip_cnt(clip_cnt)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic do_clear(input bit rnd, input int stop_at);
    int exp_a, errs;
    bit fin;
    fb_ready = 1; clear = 1; bg_cidx = 3; x = 2; y = 0; cidx = 7; drawing = 1;
    step;
    clear = 0; bg_cidx = 0; drawing = 0;
    chk("cw_we", fb_we, 1);
    chk("cw_addr", fb_addr, 2);
    chk("cw_din", fb_din, 7);
    chk("cw_oe", oe, 0);
    chk("cw_busy", busy, 1);
    step;
    exp_a = 0; errs = 0; fin = 0;
    for (int c = 0; c < 70000 && !fin; c++) begin
      fb_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      clear = (c == 5);
      #1;
      if (!fb_we || fb_addr != 16'(exp_a) || fb_din != 4'd3 || oe || clear_done || !busy) errs++;
      if (stop_at >= 0 && exp_a == stop_at) begin
        rst = 1;
        fin = 1;
      end else if (fb_ready) begin
        fin = (exp_a == 57599);
        exp_a++;
      end
      step;
    end
    clear = 0;
    chk("clear_seq_errs", errs, 0);
    chk("clear_finished", fin, 1);
    if (stop_at < 0) begin
      chk("clear_done_hi", clear_done, 1);
      chk("clear_end_we", fb_we, 0);
      chk("clear_end_oe", oe, 1);
      chk("clear_end_busy", busy, 0);
      chk("clear_count", exp_a, 57600);
      step;
      chk("clear_done_lo", clear_done, 0);
    end else begin
      chk("rst_we", fb_we, 0);
      chk("rst_done", clear_done, 0);
      chk("rst_oe", oe, 0);
      chk("rst_busy", busy, 0);
      rst = 0;
      #1;
      chk("post_rst_oe", oe, 1);
      x = 4; y = 3; cidx = 5; drawing = 1;
      step;
      drawing = 0;
      chk("post_rst_we", fb_we, 1);
      chk("post_rst_addr", fb_addr, 964);
      chk("post_rst_din", fb_din, 5);
      chk("post_rst_done", clear_done, 0);
      step;
    end
  endtask
  initial begin
    v[0]  = '{10, 2, 5, 1, 650};
    v[1]  = '{0, 0, 1, 1, 0};
    v[2]  = '{319, 179, 7, 1, 57599};
    v[3]  = '{1, 0, 2, 1, 1};
    v[4]  = '{319, 0, 4, 1, 319};
    v[5]  = '{0, 1, 6, 1, 320};
    v[6]  = '{-1, 0, 3, 0, 0};
    v[7]  = '{320, 5, 3, 0, 0};
    v[8]  = '{0, 180, 3, 0, 0};
    v[9]  = '{5, -3, 3, 0, 0};
    v[10] = '{0, 0, 9, 1, 0};
    v[11] = '{200, 100, 3, 1, 32200};
    step;
    step;
    chk("rst_fb_we", fb_we, 0);
    chk("rst_oe", oe, 0);
    chk("rst_clip", clip_cnt, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    step;
    chk("rel_oe", oe, 1);
    fb_ready = 1;
    for (int i = 0; i < 12; i++) begin
      x = 16'(v[i].x); y = 16'(v[i].y); cidx = 4'(v[i].cidx); drawing = 1;
      #1;
      chk("vec_oe", oe, 1);
      step;
      chk("vec_we", fb_we, v[i].we);
      if (v[i].we != 0) begin
        chk("vec_addr", fb_addr, v[i].addr);
        chk("vec_din", fb_din, v[i].cidx);
      end
    end
    drawing = 0;
    chk("clip_cnt", clip_cnt, 4);
    step;
    chk("idle_we", fb_we, 0);
    fb_ready = 0; x = 0; y = 0; cidx = 4; drawing = 1;
    #1;
    chk("stall_oe_pre", oe, 1);
    step;
    chk("stall_we0", fb_we, 1);
    chk("stall_addr0", fb_addr, 0);
    x = 319; y = 179; cidx = 6; drawing = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_oe", oe, 0);
      step;
      chk("stall_hold_we", fb_we, 1);
      chk("stall_hold_addr", fb_addr, 0);
      chk("stall_hold_din", fb_din, 4);
    end
    fb_ready = 1;
    #1;
    chk("unstall_oe", oe, 1);
    drawing = 1;
    step;
    chk("stream_addr1", fb_addr, 57599);
    chk("stream_din1", fb_din, 6);
    x = 1; y = 0; cidx = 2;
    step;
    chk("stream_addr2", fb_addr, 1);
    chk("stream_din2", fb_din, 2);
    drawing = 0;
    step;
    chk("stream_end_we", fb_we, 0);
    do_clear(0, -1);
    do_clear(1, 1000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
